// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and multi-cycle-execute control for a 5-stage int/float pipeline.
// Latency: the select, stall and hold outputs are combinational from the stage records and D inputs; the records update every clock.
// Backpressure: stall_fd holds PC and F/D; e_hold freezes E and sends bubbles into M; redirect sends a bubble into E.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   d_*                      decoded D-stage instruction (sources, destination, load / multi-cycle flags)
//   redirect                 E resolved a taken jump or mispredict; the D instruction is discarded
//   stall_fd, e_hold         pipeline register enables
//   d_fwd_sel, e_fwd_sel     operand bypass selects for D and E
//   w_we, w_rd, w_cls        W-stage register-file write controls
//   mc_done                  multi-cycle result is valid at the end of this E cycle
//   stall_cnt                saturating count of stall_fd cycles
module pipe_hazard_unit #(
  parameter int RA_W   = 5,
  parameter int NSRC   = 2,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_valid,
  input  logic [NSRC*RA_W-1:0]   d_rs,
  input  logic [NSRC-1:0]        d_rs_use,
  input  logic [NSRC-1:0]        d_rs_cls,
  input  logic [RA_W-1:0]        d_rd,
  input  logic                   d_rd_we,
  input  logic                   d_rd_cls,
  input  logic                   d_is_load,
  input  logic                   d_is_mc,
  input  logic                   redirect,
  output logic                   stall_fd,
  output logic                   e_hold,
  output logic [NSRC-1:0]        d_fwd_sel,
  output logic [2*NSRC-1:0]      e_fwd_sel,
  output logic                   w_we,
  output logic [RA_W-1:0]        w_rd,
  output logic                   w_cls,
  output logic                   mc_done,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int             MCW      = $clog2(MC_LAT) + 1;
  localparam logic [MCW-1:0] MC_LOAD  = MCW'(MC_LAT - 1);
  localparam logic           MC_MULTI = (MC_LAT > 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_t;

  // E stage record (including the source operands it reads)
  logic                 r_e_valid;
  logic                 r_e_we;
  logic [RA_W-1:0]      r_e_rd;
  logic                 r_e_cls;
  logic                 r_e_load;
  logic                 r_e_mc;
  logic [NSRC*RA_W-1:0] r_e_rs;
  logic [NSRC-1:0]      r_e_rs_use;
  logic [NSRC-1:0]      r_e_rs_cls;

  // M stage record
  logic                 r_m_valid;
  logic                 r_m_we;
  logic [RA_W-1:0]      r_m_rd;
  logic                 r_m_cls;
  logic                 r_m_load;
  logic                 r_m_mc;

  // W stage record
  logic                 r_w_valid;
  logic                 r_w_we;
  logic [RA_W-1:0]      r_w_rd;
  logic                 r_w_cls;
  logic                 r_w_load;
  logic                 r_w_mc;

  mc_state_t            r_mc_state;
  mc_state_t            w_mc_state_nxt;
  logic [MCW-1:0]       r_mc_cnt;
  logic [MCW-1:0]       w_mc_cnt_nxt;

  logic [CNT_W-1:0]     r_stall_cnt;

  logic [NSRC-1:0]      w_d_fwd_sel;
  logic [2*NSRC-1:0]    w_e_fwd_sel;
  logic                 w_load_use;
  logic                 w_e_hold;
  logic                 w_stall_fd;
  logic                 w_e_capture;

  // A source matches a stage's write when the stage writes the same register
  // of the same class. Integer x0 is hardwired to zero and never matches;
  // float f0 is a real register and does.
  function automatic logic f_match(
    input logic            x_valid,
    input logic            x_we,
    input logic [RA_W-1:0] x_rd,
    input logic            x_cls,
    input logic            src_use,
    input logic            src_cls,
    input logic [RA_W-1:0] src_rs
  );
    return x_valid & x_we & src_use & (x_cls == src_cls) & (x_rd == src_rs) &
           !((src_cls == 1'b0) && (src_rs == '0));
  endfunction

  // Bypass selects and load-use detection
  always_comb begin
    w_d_fwd_sel = '0;
    w_e_fwd_sel = '0;
    w_load_use  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      // E operands: the younger producer (M) wins over W
      if (f_match(r_m_valid, r_m_we, r_m_rd, r_m_cls,
                  r_e_rs_use[i], r_e_rs_cls[i], r_e_rs[i*RA_W +: RA_W])) begin
        w_e_fwd_sel[2*i +: 2] = 2'b01;
      end else if (f_match(r_w_valid, r_w_we, r_w_rd, r_w_cls,
                           r_e_rs_use[i], r_e_rs_cls[i], r_e_rs[i*RA_W +: RA_W])) begin
        w_e_fwd_sel[2*i +: 2] = 2'b00;
      end else begin
        w_e_fwd_sel[2*i +: 2] = 2'b10;
      end

      // D reads the register file in the same cycle W writes it
      w_d_fwd_sel[i] = f_match(r_w_valid, r_w_we, r_w_rd, r_w_cls,
                               d_rs_use[i], d_rs_cls[i], d_rs[i*RA_W +: RA_W]);

      // A load in E has no data until W, so its consumer must wait one cycle
      if (d_valid && r_e_valid && r_e_load &&
          f_match(r_e_valid, r_e_we, r_e_rd, r_e_cls,
                  d_rs_use[i], d_rs_cls[i], d_rs[i*RA_W +: RA_W])) begin
        w_load_use = 1'b1;
      end
    end
  end

  assign w_e_hold    = (r_mc_state == ST_BUSY);
  // Redirect discards D, so a pending load-use is moot; redirect never
  // coincides with a hold because multi-cycle ops do not redirect.
  assign w_stall_fd  = w_e_hold | (w_load_use & !redirect);
  assign w_e_capture = d_valid & !redirect & !w_stall_fd;

  // Multi-cycle FSM: the counter holds the remaining held cycles in E
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mc_state <= ST_IDLE;
      r_mc_cnt   <= '0;
    end else begin
      r_mc_state <= w_mc_state_nxt;
      r_mc_cnt   <= w_mc_cnt_nxt;
    end
  end

  always_comb begin
    w_mc_state_nxt = r_mc_state;
    w_mc_cnt_nxt   = r_mc_cnt;
    case (r_mc_state)
      ST_IDLE: begin
        if (w_e_capture && d_is_mc && MC_MULTI) begin
          w_mc_state_nxt = ST_BUSY;
          w_mc_cnt_nxt   = MC_LOAD;
        end
      end
      ST_BUSY: begin
        w_mc_cnt_nxt = r_mc_cnt - 1'b1;
        if (r_mc_cnt == MCW'(1)) begin
          w_mc_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_mc_state_nxt = ST_IDLE;
        w_mc_cnt_nxt   = '0;
      end
    endcase
  end

  // Stage record advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_valid  <= 1'b0;
      r_e_we     <= 1'b0;
      r_e_rd     <= '0;
      r_e_cls    <= 1'b0;
      r_e_load   <= 1'b0;
      r_e_mc     <= 1'b0;
      r_e_rs     <= '0;
      r_e_rs_use <= '0;
      r_e_rs_cls <= '0;
      r_m_valid  <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_rd     <= '0;
      r_m_cls    <= 1'b0;
      r_m_load   <= 1'b0;
      r_m_mc     <= 1'b0;
      r_w_valid  <= 1'b0;
      r_w_we     <= 1'b0;
      r_w_rd     <= '0;
      r_w_cls    <= 1'b0;
      r_w_load   <= 1'b0;
      r_w_mc     <= 1'b0;
    end else begin
      r_w_valid <= r_m_valid;
      r_w_we    <= r_m_we;
      r_w_rd    <= r_m_rd;
      r_w_cls   <= r_m_cls;
      r_w_load  <= r_m_load;
      r_w_mc    <= r_m_mc;

      if (w_e_hold) begin
        // E keeps the multi-cycle op; M gets a bubble
        r_m_valid <= 1'b0;
        r_m_we    <= 1'b0;
        r_m_rd    <= '0;
        r_m_cls   <= 1'b0;
        r_m_load  <= 1'b0;
        r_m_mc    <= 1'b0;
      end else begin
        r_m_valid <= r_e_valid;
        r_m_we    <= r_e_we;
        r_m_rd    <= r_e_rd;
        r_m_cls   <= r_e_cls;
        r_m_load  <= r_e_load;
        r_m_mc    <= r_e_mc;

        if (w_e_capture) begin
          r_e_valid  <= 1'b1;
          r_e_we     <= d_rd_we;
          r_e_rd     <= d_rd;
          r_e_cls    <= d_rd_cls;
          r_e_load   <= d_is_load;
          r_e_mc     <= d_is_mc;
          r_e_rs     <= d_rs;
          r_e_rs_use <= d_rs_use;
          r_e_rs_cls <= d_rs_cls;
        end else begin
          r_e_valid  <= 1'b0;
          r_e_we     <= 1'b0;
          r_e_rd     <= '0;
          r_e_cls    <= 1'b0;
          r_e_load   <= 1'b0;
          r_e_mc     <= 1'b0;
          r_e_rs     <= '0;
          r_e_rs_use <= '0;
          r_e_rs_cls <= '0;
        end
      end
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall_fd && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_fd  = w_stall_fd;
  assign e_hold    = w_e_hold;
  assign d_fwd_sel = w_d_fwd_sel;
  assign e_fwd_sel = w_e_fwd_sel;
  assign w_we      = r_w_valid & r_w_we;
  assign w_rd      = r_w_rd;
  assign w_cls     = r_w_cls;
  // The held op's last E cycle is the first one back in IDLE
  assign mc_done   = (r_mc_state == ST_IDLE) & r_e_valid & r_e_mc;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed testbench for pipe_hazard_unit (RA_W=5, NSRC=2, MC_LAT=4, CNT_W=16).
// Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later.
// Expected values are hand-derived from the pipeline timing of each sequence.
module tb_pipe_hazard_unit;

  logic        clk;
  logic        rst;
  logic        d_valid;
  logic [9:0]  d_rs;
  logic [1:0]  d_rs_use;
  logic [1:0]  d_rs_cls;
  logic [4:0]  d_rd;
  logic        d_rd_we;
  logic        d_rd_cls;
  logic        d_is_load;
  logic        d_is_mc;
  logic        redirect;
  logic        stall_fd;
  logic        e_hold;
  logic [1:0]  d_fwd_sel;
  logic [3:0]  e_fwd_sel;
  logic        w_we;
  logic [4:0]  w_rd;
  logic        w_cls;
  logic        mc_done;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_bad = 0;

  pipe_hazard_unit #(
    .RA_W(5), .NSRC(2), .MC_LAT(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs(d_rs), .d_rs_use(d_rs_use),
    .d_rs_cls(d_rs_cls), .d_rd(d_rd), .d_rd_we(d_rd_we), .d_rd_cls(d_rd_cls),
    .d_is_load(d_is_load), .d_is_mc(d_is_mc), .redirect(redirect),
    .stall_fd(stall_fd), .e_hold(e_hold), .d_fwd_sel(d_fwd_sel), .e_fwd_sel(e_fwd_sel),
    .w_we(w_we), .w_rd(w_rd), .w_cls(w_cls), .mc_done(mc_done), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive the D-stage instruction, then settle before checks
  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs0,
                     input logic [1:0] use_i, input logic [1:0] cls_i,
                     input logic [4:0] rd, input logic we, input logic rdcls,
                     input logic ld, input logic mc);
    d_valid   = v;
    d_rs      = {rs1, rs0};
    d_rs_use  = use_i;
    d_rs_cls  = cls_i;
    d_rd      = rd;
    d_rd_we   = we;
    d_rd_cls  = rdcls;
    d_is_load = ld;
    d_is_mc   = mc;
    #1;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) begin
      nop();
      cyc();
    end
  endtask

  initial begin
    rst      = 1'b1;
    redirect = 1'b0;
    nop();
    cyc();
    cyc();
    // reset state
    chk("rst_stall_fd",  32'(stall_fd),  32'd0);
    chk("rst_e_hold",    32'(e_hold),    32'd0);
    chk("rst_d_fwd",     32'(d_fwd_sel), 32'd0);
    chk("rst_e_fwd",     32'(e_fwd_sel), 32'b1010);
    chk("rst_w_we",      32'(w_we),      32'd0);
    chk("rst_w_rd",      32'(w_rd),      32'd0);
    chk("rst_w_cls",     32'(w_cls),     32'd0);
    chk("rst_mc_done",   32'(mc_done),   32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    cyc();

    // back-to-back dependency: add x5; sub x6,x5; or x8,x5; and (reads x5)
    drv(1, 5'd2, 5'd1, 2'b11, 2'b00, 5'd5, 1, 0, 0, 0);
    cyc();
    drv(1, 5'd0, 5'd5, 2'b01, 2'b00, 5'd6, 1, 0, 0, 0);
    chk("b2b_no_stall", 32'(stall_fd), 32'd0);
    cyc();
    drv(1, 5'd0, 5'd5, 2'b01, 2'b00, 5'd8, 1, 0, 0, 0);
    chk("b2b_fwd_m", 32'(e_fwd_sel), 32'b1001);
    chk("b2b_no_stall2", 32'(stall_fd), 32'd0);
    cyc();
    drv(1, 5'd5, 5'd0, 2'b10, 2'b00, 5'd0, 0, 0, 0, 0);
    chk("b2b_fwd_w", 32'(e_fwd_sel), 32'b1000);
    chk("b2b_d_fwd", 32'(d_fwd_sel), 32'b10);
    chk("b2b_w_we", 32'(w_we), 32'd1);
    chk("b2b_w_rd", 32'(w_rd), 32'd5);
    cyc();
    drain();

    // load-use: lw x7; add rs2=x7
    drv(1, 5'd0, 5'd2, 2'b01, 2'b00, 5'd7, 1, 0, 1, 0);
    cyc();
    drv(1, 5'd7, 5'd1, 2'b10, 2'b00, 5'd9, 1, 0, 0, 0);
    chk("lu_stall", 32'(stall_fd), 32'd1);
    chk("lu_cnt0", 32'(stall_cnt), 32'd0);
    cyc();
    chk("lu_stall_once", 32'(stall_fd), 32'd0);
    chk("lu_cnt1", 32'(stall_cnt), 32'd1);
    cyc();
    nop();
    chk("lu_fwd_w", 32'(e_fwd_sel), 32'b0010);
    cyc();
    drain();

    // load to x0 never stalls
    drv(1, 5'd0, 5'd2, 2'b01, 2'b00, 5'd0, 1, 0, 1, 0);
    cyc();
    drv(1, 5'd0, 5'd1, 2'b10, 2'b00, 5'd9, 1, 0, 0, 0);
    chk("lu_x0_no_stall", 32'(stall_fd), 32'd0);
    cyc();
    drain();

    // class isolation: flw f3 then int add reading x3
    drv(1, 5'd0, 5'd2, 2'b01, 2'b00, 5'd3, 1, 1, 1, 0);
    cyc();
    drv(1, 5'd0, 5'd3, 2'b01, 2'b00, 5'd11, 1, 0, 0, 0);
    chk("cls_no_stall", 32'(stall_fd), 32'd0);
    cyc();
    nop();
    chk("cls_no_fwd", 32'(e_fwd_sel), 32'b1010);
    cyc();
    drain();

    // f0 is a real register: fmv f0; fadd rs1=f0
    drv(1, 5'd0, 5'd4, 2'b01, 2'b01, 5'd0, 1, 1, 0, 0);
    cyc();
    drv(1, 5'd0, 5'd0, 2'b01, 2'b01, 5'd5, 1, 1, 0, 0);
    chk("f0_no_stall", 32'(stall_fd), 32'd0);
    cyc();
    nop();
    chk("f0_fwd_m", 32'(e_fwd_sel), 32'b1001);
    cyc();
    drain();

    // multi-cycle: mul x10; dependent mul x12 back-to-back
    drv(1, 5'd2, 5'd1, 2'b11, 2'b00, 5'd10, 1, 0, 0, 1);
    cyc();
    drv(1, 5'd0, 5'd10, 2'b01, 2'b00, 5'd12, 1, 0, 0, 1);
    chk("mc1_hold_c1", 32'(e_hold), 32'd1);
    chk("mc1_stall_c1", 32'(stall_fd), 32'd1);
    chk("mc1_done_c1", 32'(mc_done), 32'd0);
    cyc();
    chk("mc1_hold_c2", 32'(e_hold), 32'd1);
    cyc();
    chk("mc1_hold_c3", 32'(e_hold), 32'd1);
    chk("mc1_w_bubble", 32'(w_we), 32'd0);
    cyc();
    chk("mc1_hold_c4", 32'(e_hold), 32'd0);
    chk("mc1_done_c4", 32'(mc_done), 32'd1);
    chk("mc1_stall_c4", 32'(stall_fd), 32'd0);
    chk("mc1_cnt", 32'(stall_cnt), 32'd4);
    cyc();
    nop();
    chk("mc2_hold_c1", 32'(e_hold), 32'd1);
    chk("mc2_done_c1", 32'(mc_done), 32'd0);
    chk("mc2_fwd_m", 32'(e_fwd_sel), 32'b1001);
    chk("mc2_stall_c1", 32'(stall_fd), 32'd1);
    cyc();
    chk("mc2_hold_c2", 32'(e_hold), 32'd1);
    chk("mc1_w_we", 32'(w_we), 32'd1);
    chk("mc1_w_rd", 32'(w_rd), 32'd10);
    cyc();
    chk("mc2_hold_c3", 32'(e_hold), 32'd1);
    cyc();
    chk("mc2_hold_c4", 32'(e_hold), 32'd0);
    chk("mc2_done_c4", 32'(mc_done), 32'd1);
    chk("mc2_cnt", 32'(stall_cnt), 32'd7);
    cyc();
    drain();

    // redirect with load-use pending in D
    drv(1, 5'd0, 5'd2, 2'b01, 2'b00, 5'd7, 1, 0, 1, 0);
    cyc();
    redirect = 1'b1;
    drv(1, 5'd7, 5'd1, 2'b10, 2'b00, 5'd9, 1, 0, 0, 0);
    chk("rd_no_stall", 32'(stall_fd), 32'd0);
    cyc();
    redirect = 1'b0;
    drv(1, 5'd0, 5'd7, 2'b01, 2'b00, 5'd13, 1, 0, 0, 0);
    chk("rd_next_no_stall", 32'(stall_fd), 32'd0);
    chk("rd_cnt", 32'(stall_cnt), 32'd7);
    cyc();
    nop();
    chk("rd_next_fwd_w", 32'(e_fwd_sel), 32'b1000);
    cyc();
    chk("rd_bubble_w", 32'(w_we), 32'd0);
    cyc();
    drain();

    // reset in the 2nd BUSY cycle
    drv(1, 5'd2, 5'd1, 2'b11, 2'b00, 5'd20, 1, 0, 0, 0);
    cyc();
    drv(1, 5'd0, 5'd20, 2'b01, 2'b00, 5'd21, 1, 0, 0, 1);
    cyc();
    nop();
    chk("rb_hold_c1", 32'(e_hold), 32'd1);
    chk("rb_fwd_m", 32'(e_fwd_sel), 32'b1001);
    cyc();
    chk("rb_hold_c2", 32'(e_hold), 32'd1);
    chk("rb_w_we_pre", 32'(w_we), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rb_hold", 32'(e_hold), 32'd0);
    chk("rb_done", 32'(mc_done), 32'd0);
    chk("rb_cnt", 32'(stall_cnt), 32'd0);
    chk("rb_fwd", 32'(e_fwd_sel), 32'b1010);
    chk("rb_w_we", 32'(w_we), 32'd0);
    cyc();
    chk("rb_hold_next", 32'(e_hold), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
